mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 src_a  input  32  multiplicand / dividend (rs).
REQ-008 src_b  input  32  multiplier / divisor (rt).
REQ-009 flush  input  1  synchronous abort of the current operation.
REQ-010 busy  output  1  operation in progress; pipeline stall request.
REQ-011 HI_we  output  1  HI register write enable, one-cycle pulse.
REQ-012 LO_we  output  1  LO register write enable, one-cycle pulse.
REQ-013 HIwdata  output  32  HI write data.
REQ-014 LOwdata  output  32  LO write data.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-016 In IDLE with start=1 and flush=0, the edge SHALL latch op, |src_a| and |src_b| (magnitudes for signed ops, raw values for unsigned ops) plus the result-sign flags, and SHALL enter CALC.
REQ-017 CALC SHALL last exactly 32 cycles: one iteration per edge, using shift-add for multiply and restoring shift-subtract for divide; it SHALL then enter DONE.
REQ-018 DONE SHALL last one cycle, SHALL assert HI_we=LO_we=1 with final results, and SHALL return to IDLE on the next edge.
REQ-019 busy SHALL be 1 in CALC and DONE (33 cycles after the accepting edge) and 0 in IDLE.
REQ-020 start SHALL be ignored when the state is not IDLE, including the DONE cycle.
REQ-021 For multiply, the 64-bit product SHALL be split with HIwdata=product[63:32] and LOwdata=product[31:0].
REQ-022 MULT SHALL negate the 64-bit magnitude product when src_a[31]^src_b[31]=1.
REQ-023 For divide, LOwdata SHALL be the quotient and HIwdata the remainder.
REQ-024 DIV SHALL make the quotient negative when src_a[31]^src_b[31] and the remainder carry the sign of src_a.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000, HI=0.
REQ-026 Divide by zero (src_b=0, DIV or DIVU) SHALL take the same 33-cycle latency and produce LO=0xFFFFFFFF, HI=src_a as latched.
REQ-027 flush=1 in any state SHALL force IDLE on the next edge and force HI_we=LO_we=0 combinationally in that cycle, including in DONE.
REQ-028 When both start=1 and flush=1 in IDLE, flush SHALL win and nothing SHALL be accepted.
REQ-029 HI_we and LO_we SHALL always be equal.
REQ-030 Outside DONE, HI_we=LO_we=0; HIwdata and LOwdata SHALL hold their last values and SHALL NOT be used.

Reset
REQ-031 resetn=0 SHALL immediately force the state to IDLE and drive busy=0, HI_we=LO_we=0, HIwdata=LOwdata=0, with all internal registers cleared, regardless of the clock.
REQ-032 Reset asserted mid-CALC or in DONE SHALL discard the operation with no write pulse.
REQ-033 After resetn deasserts, the first start in IDLE SHALL be accepted normally.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> in cycle 33 after accept: HI_we=LO_we=1, HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 33 cycles.
REQ-035 MULT 0xFFFFFFFD x 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-036 DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 -> LO=3, HI=1.
REQ-037 DIV 0x12345678 / 0 -> LO=0xFFFFFFFF, HI=0x12345678 after 33 cycles; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 Flush at CALC cycle 10 -> busy=0 the next cycle with no write pulse ever; start pulsed during CALC and DONE -> ignored, exactly one write pulse.
REQ-039 resetn pulsed low mid-CALC between clock edges -> busy, HI_we, HIwdata and LOwdata go to 0 immediately; the next start completes correctly.

Source files
------------

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit multiply/divide unit producing HI/LO writes
//
// Purpose: MULT/MULTU by shift-add and DIV/DIVU by restoring shift-subtract.
// Each operation takes 32 CALC cycles followed by one DONE cycle that
// pulses HI_we/LO_we with the final results.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   start, op           request and operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b        multiplicand/dividend, multiplier/divisor
//   flush               abort; forces IDLE and suppresses the write pulse
//   busy                high in CALC and DONE
//   HI_we, LO_we        write enables, pulsed together in DONE
//   HIwdata, LOwdata    result data, held between operations
module mul_div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        HI_we,
    output logic        LO_we,
    output logic [31:0] HIwdata,
    output logic [31:0] LOwdata
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic        is_div_q, is_div_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        signed_op;
    logic [31:0] mag_a, mag_b;
    logic [32:0] sum33, rem33, diff33;
    logic [63:0] step, prod;
    logic [31:0] quo, rem;

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        signed_op = ~op[0];
        mag_a = (signed_op && src_a[31]) ? -src_a : src_a;
        mag_b = (signed_op && src_b[31]) ? -src_b : src_b;

        // Multiply: acc = {partial high, remaining multiplier bits}; add the
        // multiplicand into the high half when the current multiplier bit is set.
        sum33 = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        // Divide: acc = {remainder, dividend bits / quotient bits}.
        rem33  = acc_q[63:31];
        diff33 = rem33 - {1'b0, opnd_q};
        if (is_div_q) begin
            step = diff33[32] ? {rem33[31:0], acc_q[30:0], 1'b0}
                              : {diff33[31:0], acc_q[30:0], 1'b1};
        end else begin
            step = {sum33, acc_q[31:1]};
        end
        prod = neg_q ? -step : step;
        quo  = step[31:0];
        rem  = step[63:32];

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    is_div_d = op[1];
                    neg_d    = signed_op & (src_a[31] ^ src_b[31]);
                    rneg_d   = signed_op & src_a[31];
                    dz_d     = op[1] & (src_b == 32'd0);
                    cnt_d    = 5'd0;
                    if (op[1]) begin
                        acc_d  = {32'd0, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {32'd0, mag_b};
                        opnd_d = mag_a;
                    end
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    if (is_div_q) begin
                        // Zero divisor leaves remainder = |dividend|; re-signing
                        // it reproduces the raw dividend for HI.
                        lo_d = dz_q ? 32'hFFFF_FFFF : (neg_q ? -quo : quo);
                        hi_d = rneg_q ? -rem : rem;
                    end else begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            opnd_q   <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign HI_we   = (state_q == DONE) && !flush;
    assign LO_we   = HI_we;
    assign HIwdata = hi_q;
    assign LOwdata = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, HI_we, LO_we;
    logic [31:0] HIwdata, LOwdata;

    int n_cmp = 0;
    int n_bad = 0;

    mul_div_unit dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .HI_we(HI_we), .LO_we(LO_we),
        .HIwdata(HIwdata), .LOwdata(LOwdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit integers.
    function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        if (!mop[1]) begin
            if (mop[0]) p = 64'(a) * 64'(b);
            else        p = 64'(longint'($signed(a)) * longint'($signed(b)));
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else begin
            sa = mop[0] ? longint'({32'd0, a}) : longint'($signed(a));
            sb = mop[0] ? longint'({32'd0, b}) : longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    // Issues one operation, watches 40 cycles after the accepting edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int nbusy, output int npulse, output int pcyc);
        nbusy = 0; npulse = 0; pcyc = -1; hi = 'x; lo = 'x;
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (busy) nbusy++;
            if (HI_we !== LO_we) check("we_equal", {63'd0, HI_we}, {63'd0, LO_we});
            if (HI_we) begin
                npulse++;
                pcyc = i;
                hi = HIwdata;
                lo = LOwdata;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] hi, lo;
        int nb, np, pc;
        run_op(o, a, b, hi, lo, nb, np, pc);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
        check({tag, "_pulses"}, 64'(np), 64'd1);
        check({tag, "_busy_cycles"}, 64'(nb), 64'd33);
        check({tag, "_pulse_cycle"}, 64'(pc), 64'd33);
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] mhi, mlo, ra, rb, hi, lo;
        logic [1:0]  rop;
        int nb, np, pc;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd7,         32'd2,         32'd1,         32'd3};
        vecs[4] = '{2'b10, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[6] = '{2'b11, 32'h8765_4321, 32'd0,         32'h8765_4321, 32'hFFFF_FFFF};
        vecs[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

        // Reset state
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hi_we", {63'd0, HI_we}, 64'd0);
        check("rst_lo_we", {63'd0, LO_we}, 64'd0);
        check("rst_hiw", {32'd0, HIwdata}, 64'd0);
        check("rst_low", {32'd0, LOwdata}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Randomized against the reference model
        for (int k = 0; k < 24; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = -32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, mhi, mlo);
            run_check($sformatf("rand%0d", k), rop, ra, rb, mhi, mlo);
        end

        // Flush at CALC cycle 10: no pulse ever
        @(negedge clk);
        op = 2'b01; src_a = 32'd123; src_b = 32'd456; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i <= 10; i++) @(negedge clk);
        flush = 1'b1;
        #1 check("flush_calc_we", {63'd0, HI_we}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_calc_busy", {63'd0, busy}, 64'd0);
        np = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (HI_we || LO_we) np++;
        end
        check("flush_calc_pulses", 64'(np), 64'd0);

        // Flush during DONE suppresses the pulse in that cycle
        @(negedge clk);
        op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i <= 33; i++) @(negedge clk);
        check("pre_flush_done_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        #1 check("flush_done_we", {62'd0, HI_we, LO_we}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_busy", {63'd0, busy}, 64'd0);

        // start+flush together in IDLE: nothing accepted
        op = 2'b00; src_a = 32'd3; src_b = 32'd4; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush_busy", {63'd0, busy}, 64'd0);

        // start held through CALC and DONE: ignored, exactly one pulse
        @(negedge clk);
        op = 2'b00; src_a = 32'hFFFF_FF00; src_b = 32'd3; start = 1'b1;
        model(2'b00, 32'hFFFF_FF00, 32'd3, mhi, mlo);
        @(posedge clk);
        np = 0; hi = 'x; lo = 'x;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
            if (HI_we) begin np++; hi = HIwdata; lo = LOwdata; end
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (HI_we) np++;
        end
        check("held_start_pulses", 64'(np), 64'd1);
        check("held_start_hi", {32'd0, hi}, {32'd0, mhi});
        check("held_start_lo", {32'd0, lo}, {32'd0, mlo});
        check("held_start_idle", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i <= 10; i++) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_we", {62'd0, HI_we, LO_we}, 64'd0);
        check("arst_hiw", {32'd0, HIwdata}, 64'd0);
        check("arst_low", {32'd0, LOwdata}, 64'd0);
        #1 resetn = 1'b1;
        np = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (HI_we || busy) np++;
        end
        check("arst_no_resume", 64'(np), 64'd0);
        run_check("post_reset", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
